vector_register_bank: RTL and testbench

Parametrised multi-port vector register file succeeding the single-write, four-read combinational file in the register-read stage. Provides a configurable number of read and write ports, per-element masked writes, same-cycle write-to-read forwarding, registered one-cycle reads, and a busy scoreboard. The scoreboard lets issue logic detect reads of registers whose producer has not yet written back. It sits between decode/issue and the vector execution lanes.

---
 rtl/vector_register_bank_pkg.sv | 29 ++
 rtl/vector_register_bank_if.sv | 45 ++++
 rtl/vector_register_scoreboard.sv | 55 +++++
 rtl/vector_register_bank.sv | 98 +++++++++
 tb/tb_vector_register_bank.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/vector_register_bank_pkg.sv
// Shared helpers for the vector register bank: derived widths, element indexing
// and parameter legality predicates evaluated at elaboration.
package vector_register_bank_pkg;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned mask_width(input int unsigned length, input int unsigned granule);
    return length / granule;
  endfunction

  function automatic int unsigned element_lsb(input int unsigned index, input int unsigned granule);
    return index * granule;
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit granule_divides(input int unsigned length, input int unsigned granule);
    return (granule != 0) && ((length % granule) == 0);
  endfunction

  function automatic bit in_range(input int unsigned value, input int unsigned lo, input int unsigned hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/vector_register_bank_if.sv
// Issue-side bundle of the vector register bank: read, write, reserve and
// scoreboard signals. master = issue/execute side, slave = register bank.
interface vector_register_bank_if #(
  parameter int unsigned NUMBER_REGISTERS   = 32,
  parameter int unsigned REGISTER_LENGTH    = 64,
  parameter int unsigned ELEMENT_WIDTH      = 8,
  parameter int unsigned NUMBER_READ_PORTS  = 4,
  parameter int unsigned NUMBER_WRITE_PORTS = 2
) ();
  import vector_register_bank_pkg::*;

  localparam int unsigned AW = addr_width(NUMBER_REGISTERS);
  localparam int unsigned MW = mask_width(REGISTER_LENGTH, ELEMENT_WIDTH);

  logic [NUMBER_READ_PORTS-1:0]                      read_enable;
  logic [NUMBER_READ_PORTS-1:0][AW-1:0]              read_address;
  logic [NUMBER_READ_PORTS-1:0][REGISTER_LENGTH-1:0] read_port;
  logic [NUMBER_READ_PORTS-1:0]                      read_busy;

  logic [NUMBER_WRITE_PORTS-1:0]                      write_enable;
  logic [NUMBER_WRITE_PORTS-1:0][AW-1:0]              write_address;
  logic [NUMBER_WRITE_PORTS-1:0][MW-1:0]              write_mask;
  logic [NUMBER_WRITE_PORTS-1:0][REGISTER_LENGTH-1:0] write_port;
  logic [NUMBER_WRITE_PORTS-1:0]                      write_last;

  logic                        reserve_enable;
  logic [AW-1:0]               reserve_address;
  logic                        reserve_conflict;
  logic [NUMBER_REGISTERS-1:0] busy_vector;

  modport master (
    output read_enable, read_address,
    output write_enable, write_address, write_mask, write_port, write_last,
    output reserve_enable, reserve_address,
    input  read_port, read_busy, reserve_conflict, busy_vector
  );

  modport slave (
    input  read_enable, read_address,
    input  write_enable, write_address, write_mask, write_port, write_last,
    input  reserve_enable, reserve_address,
    output read_port, read_busy, reserve_conflict, busy_vector
  );

endinterface

// File: rtl/vector_register_scoreboard.sv
// Busy-bit scoreboard: issue reserves set a bit, final write beats clear it,
// and a reserve on a still-busy register raises a one-cycle conflict pulse.
module vector_register_scoreboard #(
  parameter int unsigned NUMBER_REGISTERS   = 32,
  parameter int unsigned NUMBER_WRITE_PORTS = 2,
  parameter int unsigned AW                 = 5
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                reserve_enable,
  input  logic [AW-1:0]                       reserve_address,
  input  logic [NUMBER_WRITE_PORTS-1:0]       write_enable,
  input  logic [NUMBER_WRITE_PORTS-1:0]       write_last,
  input  logic [NUMBER_WRITE_PORTS-1:0][AW-1:0] write_address,
  output logic [NUMBER_REGISTERS-1:0]         busy_vector,
  output logic                                reserve_conflict,
  output logic [NUMBER_REGISTERS-1:0]         busy_cleared_c
);

  logic [NUMBER_REGISTERS-1:0] busy_q;
  logic [NUMBER_REGISTERS-1:0] clear_mask_c;
  logic [NUMBER_REGISTERS-1:0] set_mask_c;
  logic [NUMBER_REGISTERS-1:0] busy_next_c;
  logic                        conflict_next_c;

  // Clears apply before sets so a same-cycle reserve (the new producer) wins.
  always_comb begin
    clear_mask_c = '0;
    for (int unsigned w = 0; w < NUMBER_WRITE_PORTS; w++) begin
      if (write_enable[w] && write_last[w]) begin
        clear_mask_c[write_address[w]] = 1'b1;
      end
    end
    set_mask_c = '0;
    if (reserve_enable) begin
      set_mask_c[reserve_address] = 1'b1;
    end
    busy_cleared_c  = busy_q & ~clear_mask_c;
    busy_next_c     = busy_cleared_c | set_mask_c;
    conflict_next_c = reserve_enable & busy_cleared_c[reserve_address];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q           <= '0;
      reserve_conflict <= 1'b0;
    end else begin
      busy_q           <= busy_next_c;
      reserve_conflict <= conflict_next_c;
    end
  end

  assign busy_vector = busy_q;

endmodule

// File: rtl/vector_register_bank.sv
// Multi-port vector register file with masked writes, same-edge write-to-read
// forwarding, registered reads and a busy scoreboard for issue hazard checks.
module vector_register_bank
  import vector_register_bank_pkg::*;
#(
  parameter int unsigned NUMBER_REGISTERS   = 32,
  parameter int unsigned REGISTER_LENGTH    = 64,
  parameter int unsigned ELEMENT_WIDTH      = 8,
  parameter int unsigned NUMBER_READ_PORTS  = 4,
  parameter int unsigned NUMBER_WRITE_PORTS = 2
) (
  input logic                   clock,
  input logic                   reset_n,
  vector_register_bank_if.slave bus
);

  localparam int unsigned AW = addr_width(NUMBER_REGISTERS);
  localparam int unsigned MW = mask_width(REGISTER_LENGTH, ELEMENT_WIDTH);

  if (!is_pow2(NUMBER_REGISTERS) || NUMBER_REGISTERS < 2) begin : g_bad_depth
    $error("vector_register_bank: NUMBER_REGISTERS must be a power of two >= 2");
  end
  if (!granule_divides(REGISTER_LENGTH, ELEMENT_WIDTH)) begin : g_bad_granule
    $error("vector_register_bank: ELEMENT_WIDTH must divide REGISTER_LENGTH");
  end
  if (!in_range(NUMBER_READ_PORTS, 1, 8)) begin : g_bad_read_ports
    $error("vector_register_bank: NUMBER_READ_PORTS must be 1..8");
  end
  if (!in_range(NUMBER_WRITE_PORTS, 1, 4)) begin : g_bad_write_ports
    $error("vector_register_bank: NUMBER_WRITE_PORTS must be 1..4");
  end

  logic [NUMBER_REGISTERS-1:0][REGISTER_LENGTH-1:0]  data_q;
  logic [NUMBER_REGISTERS-1:0][REGISTER_LENGTH-1:0]  data_merged_c;
  logic [NUMBER_READ_PORTS-1:0][REGISTER_LENGTH-1:0] read_q;
  logic [NUMBER_READ_PORTS-1:0]                      read_busy_q;
  logic [NUMBER_REGISTERS-1:0]                       busy_cleared_c;

  // Ascending port order lets the highest-index port win element collisions.
  always_comb begin
    data_merged_c = data_q;
    for (int unsigned w = 0; w < NUMBER_WRITE_PORTS; w++) begin
      for (int unsigned k = 0; k < MW; k++) begin
        if (bus.write_enable[w] && bus.write_mask[w][k]) begin
          data_merged_c[bus.write_address[w]][element_lsb(k, ELEMENT_WIDTH) +: ELEMENT_WIDTH] =
            bus.write_port[w][element_lsb(k, ELEMENT_WIDTH) +: ELEMENT_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_merged_c;
    end
  end

  // Reads see the merged array, which forwards same-edge writes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_q      <= '0;
      read_busy_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NUMBER_READ_PORTS; r++) begin
        if (bus.read_enable[r]) begin
          read_q[r]      <= data_merged_c[bus.read_address[r]];
          read_busy_q[r] <= busy_cleared_c[bus.read_address[r]];
        end else begin
          read_q[r]      <= '0;
          read_busy_q[r] <= 1'b0;
        end
      end
    end
  end

  assign bus.read_port = read_q;
  assign bus.read_busy = read_busy_q;

  vector_register_scoreboard #(
    .NUMBER_REGISTERS  (NUMBER_REGISTERS),
    .NUMBER_WRITE_PORTS(NUMBER_WRITE_PORTS),
    .AW                (AW)
  ) u_scoreboard (
    .clock           (clock),
    .reset_n         (reset_n),
    .reserve_enable  (bus.reserve_enable),
    .reserve_address (bus.reserve_address),
    .write_enable    (bus.write_enable),
    .write_last      (bus.write_last),
    .write_address   (bus.write_address),
    .busy_vector     (bus.busy_vector),
    .reserve_conflict(bus.reserve_conflict),
    .busy_cleared_c  (busy_cleared_c)
  );

endmodule

// File: tb/tb_vector_register_bank.sv
// Self-checking bench for vector_register_bank: directed scenarios plus random
// traffic compared against an array/bitmask reference model.
module tb_vector_register_bank;

  localparam int unsigned NREG = 32;
  localparam int unsigned RL   = 64;
  localparam int unsigned EW   = 8;
  localparam int unsigned NRP  = 4;
  localparam int unsigned NWP  = 2;
  localparam int unsigned AW   = 5;
  localparam int unsigned MW   = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  vector_register_bank_if #(
    .NUMBER_REGISTERS(NREG), .REGISTER_LENGTH(RL), .ELEMENT_WIDTH(EW),
    .NUMBER_READ_PORTS(NRP), .NUMBER_WRITE_PORTS(NWP)
  ) bus ();

  vector_register_bank #(
    .NUMBER_REGISTERS(NREG), .REGISTER_LENGTH(RL), .ELEMENT_WIDTH(EW),
    .NUMBER_READ_PORTS(NRP), .NUMBER_WRITE_PORTS(NWP)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [RL-1:0]   mmem [NREG];
  logic [NREG-1:0] mbusy;
  logic [RL-1:0]   exp_rd [NRP];
  logic [NRP-1:0]  exp_rb;
  logic            exp_conf;

  task automatic check(input string tag, input logic [RL-1:0] obs, input logic [RL-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [RL-1:0] expand(input logic [MW-1:0] m);
    logic [RL-1:0] b;
    b = '0;
    for (int k = 0; k < MW; k++) if (m[k]) b[k*EW +: EW] = '1;
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mmem[i] = '0;
    mbusy = '0;
    for (int r = 0; r < NRP; r++) exp_rd[r] = '0;
    exp_rb   = '0;
    exp_conf = 1'b0;
  endtask

  // Reference: apply writes in port order, then reads, clears, then reserve.
  task automatic model_eval();
    logic [RL-1:0]   bm;
    logic [NREG-1:0] cleared;
    for (int w = 0; w < NWP; w++) begin
      if (bus.write_enable[w]) begin
        bm = expand(bus.write_mask[w]);
        mmem[bus.write_address[w]] = (mmem[bus.write_address[w]] & ~bm) | (bus.write_port[w] & bm);
      end
    end
    cleared = mbusy;
    for (int w = 0; w < NWP; w++)
      if (bus.write_enable[w] && bus.write_last[w]) cleared[bus.write_address[w]] = 1'b0;
    for (int r = 0; r < NRP; r++) begin
      exp_rd[r] = bus.read_enable[r] ? mmem[bus.read_address[r]] : '0;
      exp_rb[r] = bus.read_enable[r] & cleared[bus.read_address[r]];
    end
    exp_conf = bus.reserve_enable & cleared[bus.reserve_address];
    mbusy = cleared;
    if (bus.reserve_enable) mbusy[bus.reserve_address] = 1'b1;
  endtask

  task automatic compare_all();
    for (int r = 0; r < NRP; r++) begin
      check($sformatf("read_port[%0d]", r), bus.read_port[r], exp_rd[r]);
      check($sformatf("read_busy[%0d]", r), RL'(bus.read_busy[r]), RL'(exp_rb[r]));
    end
    check("reserve_conflict", RL'(bus.reserve_conflict), RL'(exp_conf));
    check("busy_vector", RL'(bus.busy_vector), RL'(mbusy));
  endtask

  task automatic step();
    model_eval();
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  task automatic idle();
    bus.read_enable     = '0;
    bus.read_address    = '0;
    bus.write_enable    = '0;
    bus.write_address   = '0;
    bus.write_mask      = '0;
    bus.write_port      = '0;
    bus.write_last      = '0;
    bus.reserve_enable  = 1'b0;
    bus.reserve_address = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [MW-1:0] m, input logic [RL-1:0] d, input bit last);
    bus.write_enable[p]  = 1'b1;
    bus.write_address[p] = AW'(a);
    bus.write_mask[p]    = m;
    bus.write_port[p]    = d;
    bus.write_last[p]    = last;
  endtask

  task automatic rd(input int p, input int a);
    bus.read_enable[p]  = 1'b1;
    bus.read_address[p] = AW'(a);
  endtask

  task automatic rsv(input int a);
    bus.reserve_enable  = 1'b1;
    bus.reserve_address = AW'(a);
  endtask

  function automatic int pick();
    return ($urandom % 2) ? int'($urandom % 8) : int'($urandom % NREG);
  endfunction

  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    compare_all();

    // Masked merge of two ports into one register.
    idle(); wr(0, 5, 8'hFF, 64'h1122334455667788, 1'b0); step();
    idle(); wr(0, 5, 8'h0F, {16{4'hA}}, 1'b0); wr(1, 5, 8'h30, {16{4'hB}}, 1'b0); step();
    idle(); rd(0, 5); step();
    check("masked_merge", bus.read_port[0], 64'h1122BBBBAAAAAAAA);

    // Full-register collision: higher port wins.
    idle(); wr(0, 7, 8'hFF, 64'h1, 1'b0); wr(1, 7, 8'hFF, 64'h2, 1'b0); step();
    idle(); rd(0, 7); step();
    check("collision", bus.read_port[0], 64'h2);

    // Same-edge forwarding to all read ports.
    idle(); wr(0, 9, 8'hFF, 64'hDEAD, 1'b0);
    for (int r = 0; r < NRP; r++) rd(r, 9);
    step();
    for (int r = 0; r < NRP; r++) check($sformatf("forward[%0d]", r), bus.read_port[r], 64'hDEAD);

    // Scoreboard reserve / read / clear / reserve-over-clear.
    idle(); rsv(4); step();
    check("reserve_sets_busy", RL'(bus.busy_vector[4]), RL'(1'b1));
    idle(); rd(0, 4); step();
    check("read_busy_set", RL'(bus.read_busy[0]), RL'(1'b1));
    idle(); wr(0, 4, 8'h01, 64'h55, 1'b1); rd(0, 4); step();
    check("read_busy_cleared", RL'(bus.read_busy[0]), RL'(1'b0));
    check("busy_cleared", RL'(bus.busy_vector[4]), RL'(1'b0));
    idle(); rsv(4); wr(1, 4, 8'h00, 64'h0, 1'b1); step();
    check("reserve_beats_clear", RL'(bus.busy_vector[4]), RL'(1'b1));
    idle(); wr(0, 4, 8'h00, 64'h0, 1'b1); step();

    // Double reserve raises a single-cycle conflict.
    idle(); rsv(2); step();
    check("conflict_first", RL'(bus.reserve_conflict), RL'(1'b0));
    idle(); rsv(2); step();
    check("conflict_second", RL'(bus.reserve_conflict), RL'(1'b1));
    idle(); step();
    check("conflict_drops", RL'(bus.reserve_conflict), RL'(1'b0));

    // Random traffic on a narrowed address range to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int r = 0; r < NRP; r++) begin
        bus.read_enable[r]  = 1'($urandom % 2);
        bus.read_address[r] = AW'(pick());
      end
      for (int w = 0; w < NWP; w++) begin
        bus.write_enable[w]  = 1'(($urandom % 3) != 0);
        bus.write_address[w] = AW'(pick());
        bus.write_mask[w]    = MW'($urandom);
        bus.write_port[w]    = {$urandom, $urandom};
        bus.write_last[w]    = 1'($urandom % 2);
      end
      bus.reserve_enable  = 1'(($urandom % 3) == 0);
      bus.reserve_address = AW'(pick());
      step();
    end

    // Reset asserted between edges while a write is pending discards it.
    idle(); wr(0, 3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    #2 reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    model_reset();
    compare_all();
    idle();
    reset_n = 1'b1;
    rd(0, 3); step();
    check("reset_v3", bus.read_port[0], 64'h0);
    check("reset_busy_vector", RL'(bus.busy_vector), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
